// File: rtl/proc_pkg.sv
// Shared processor definitions: opcode constants, sequencer state encoding
// and instruction field positions. Consumed by multicycle_sequencer and
// control_unit.
package proc_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned OPCODE_W   = 5;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 27;

  localparam logic [OPCODE_W-1:0] OP_AR   = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_T    = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11111;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALTED    = 3'd5
  } seq_state_e;

  // Opcode field of an instruction word.
  function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

  // True for opcodes that retire with a register write.
  function automatic logic is_write_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_AR) || (op == OP_T);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_fetch_timer.sv
// Fetch wait-cycle counter. Counts FETCH cycles without an acknowledge and
// flags the cycle in which the timeout budget is exhausted.
// Ports:
//   clk_i       clock
//   rst_i       asynchronous active-high reset
//   clear_i     return the count to zero (takes priority over enable_i)
//   enable_i    count this cycle
//   expired_c_o combinational: counting cycle that reaches MEM_TIMEOUT-1
module fetch_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_c_o
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise step while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_c_o = enable_i && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer. Fetches an instruction over a req/ack
// handshake, then steps it through DECODE, EXECUTE and WRITEBACK, issuing a
// single-cycle reg_write pulse in WRITEBACK for writing opcodes.
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   run                   level enable for leaving IDLE / continuing
//   imem_req/addr/ack/rdata  instruction memory handshake
//   instr, pc             instruction register and program counter
//   reg_write, sel_t      register-file write pulse, T-type select
//   busy, halted          status
//   illegal_op, mem_timeout  sticky fault flags
// Build option PERF_COUNTER_EN adds retired_count and stall_count outputs.
module multicycle_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned PC_STEP     = 4,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                run,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic [INSTR_W-1:0]  instr,
  output logic [PC_WIDTH-1:0] pc,
  output logic                reg_write,
  output logic                sel_t,
  output logic                busy,
  output logic                halted,
  output logic                illegal_op,
  output logic                mem_timeout
`ifdef PERF_COUNTER_EN
  ,
  output logic [31:0]         retired_count,
  output logic [31:0]         stall_count
`endif
);

  seq_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                req_q, req_d;
  logic                rw_q, rw_d;
  logic                sel_t_q, sel_t_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;
  logic                ill_q, ill_d;
  logic                to_q, to_d;

  logic                timer_clear;
  logic                timer_en;
  logic                timer_expired;
  logic [OPCODE_W-1:0] opcode;

  assign opcode      = get_opcode(instr_q);
  assign timer_clear = (state_q != ST_FETCH) || imem_ack;
  assign timer_en    = (state_q == ST_FETCH) && !imem_ack;

  fetch_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_fetch_timer (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .clear_i     (timer_clear),
    .enable_i    (timer_en),
    .expired_c_o (timer_expired)
  );

  // Next-state and next-output logic. Status outputs are computed from the
  // next state so they are registered yet aligned with the state they describe.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    sel_t_d = sel_t_q;
    ill_d   = ill_q;
    to_d    = to_q;

    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          // Select is valid from the first DECODE cycle onward.
          sel_t_d = (get_opcode(imem_rdata) == OP_T);
          state_d = ST_DECODE;
        end else if (timer_expired) begin
          to_d    = 1'b1;
          state_d = ST_HALTED;
        end
      end
      ST_DECODE: begin
        sel_t_d = (opcode == OP_T);
        if (opcode == OP_HALT) begin
          state_d = ST_HALTED;
        end else if (!is_write_op(opcode)) begin
          ill_d   = 1'b1;
          state_d = ST_WRITEBACK;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        pc_d    = pc_q + PC_WIDTH'(PC_STEP);
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_d    = (state_d == ST_FETCH);
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_HALTED);
    halted_d = (state_d == ST_HALTED);
    // Only the EXECUTE->WRITEBACK path writes; illegal ops skip EXECUTE.
    rw_d     = (state_q == ST_EXECUTE) && (state_d == ST_WRITEBACK) && is_write_op(opcode);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      pc_q     <= PC_WIDTH'(RESET_PC);
      instr_q  <= '0;
      req_q    <= 1'b0;
      rw_q     <= 1'b0;
      sel_t_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      ill_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      req_q    <= req_d;
      rw_q     <= rw_d;
      sel_t_q  <= sel_t_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      ill_q    <= ill_d;
      to_q     <= to_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign reg_write   = rw_q;
  assign sel_t       = sel_t_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign illegal_op  = ill_q;
  assign mem_timeout = to_q;

`ifdef PERF_COUNTER_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0] retired_q;
  logic [31:0] stall_q;

  // Saturating counts of retired instructions and fetch wait cycles.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if ((state_q == ST_WRITEBACK) && (retired_q != CNT_MAX)) begin
        retired_q <= retired_q + 32'd1;
      end
      if (timer_en && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign retired_count = retired_q;
  assign stall_count   = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer. Inputs are driven and
// outputs sampled on the falling clock edge. Expected behaviour comes from a
// per-instruction model: fetch takes waits+1 cycles, writing opcodes take
// three further cycles with reg_write in the last, illegal opcodes two, and
// each retired instruction advances the PC by 4.
module tb_multicycle_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        reg_write;
  logic        sel_t;
  logic        busy;
  logic        halted;
  logic        illegal_op;
  logic        mem_timeout;
`ifdef PERF_COUNTER_EN
  logic [31:0] retired_count;
  logic [31:0] stall_count;
`endif

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] exp_pc;
  logic        exp_ill;

  multicycle_sequencer dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .run         (run),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc          (pc),
    .reg_write   (reg_write),
    .sel_t       (sel_t),
    .busy        (busy),
    .halted      (halted),
    .illegal_op  (illegal_op),
    .mem_timeout (mem_timeout)
`ifdef PERF_COUNTER_EN
    ,
    .retired_count (retired_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    RESET      = 1'b1;
    run        = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_pc", pc, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_rw", 32'(reg_write), 32'd0);
    check("rst_sel_t", 32'(sel_t), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_ill", 32'(illegal_op), 32'd0);
    check("rst_to", 32'(mem_timeout), 32'd0);
`ifdef PERF_COUNTER_EN
    check("rst_retired", retired_count, 32'd0);
    check("rst_stall", stall_count, 32'd0);
`endif
    RESET   = 1'b0;
    exp_pc  = 32'd0;
    exp_ill = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 8 && !imem_req; i++) @(negedge CLK);
    check("req_wait", 32'(imem_req), 32'd1);
  endtask

  // Runs one instruction through the model. Starts with the DUT fetching.
  task automatic do_instr(input logic [31:0] word, input int waits, input bit drop_run);
    logic [4:0] op;
    bit         is_wr;
    bit         is_t;
    int         n_post;
    op     = word[31:27];
    is_wr  = (op == 5'b00001) || (op == 5'b00010);
    is_t   = (op == 5'b00010);
    n_post = is_wr ? 3 : 2;
    wait_req();
    check("fetch_addr", imem_addr, exp_pc);
    for (int i = 0; i <= waits; i++) begin
      check("fetch_req", 32'(imem_req), 32'd1);
      check("fetch_busy", 32'(busy), 32'd1);
      imem_ack   = (i == waits);
      imem_rdata = (i == waits) ? word : $urandom;
      @(negedge CLK);
    end
    check("decode_req", 32'(imem_req), 32'd0);
    check("decode_instr", instr, word);
    if (op == 5'b11111) begin
      imem_ack = 1'b0;
      check("halt_rw", 32'(reg_write), 32'd0);
      @(negedge CLK);
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_busy", 32'(busy), 32'd0);
      check("halt_pc", pc, exp_pc);
      return;
    end
    exp_ill = exp_ill | !is_wr;
    for (int k = 0; k < n_post; k++) begin
      // Stray acks outside FETCH must not disturb the instruction register.
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      check("post_busy", 32'(busy), 32'd1);
      check("post_instr", instr, word);
      check("post_sel_t", 32'(sel_t), 32'(is_t));
      check("post_rw", 32'(reg_write), 32'((k == n_post - 1) && is_wr));
      if (k == n_post - 1) check("post_ill", 32'(illegal_op), 32'(exp_ill));
      if (k == 1 && drop_run) run = 1'b0;
      @(negedge CLK);
    end
    imem_ack = 1'b0;
    exp_pc   = exp_pc + 32'd4;
    check("wb_pc", pc, exp_pc);
    check("wb_rw_off", 32'(reg_write), 32'd0);
    check("wb_next_req", 32'(imem_req), 32'(run));
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] word;
    int          r;
    int          cnt;

    // Reset state.
    apply_reset();

    // Ack in the first FETCH cycle with an AR instruction.
    run = 1'b1;
    do_instr(32'h0800_0000, 0, 1'b0);

    // T-type instruction.
    do_instr(32'h1008_0005, 0, 1'b0);

    // Three memory wait states.
    do_instr(32'h0812_3456, 3, 1'b0);

    // Illegal opcode 5'b00111: no write, pc still advances.
    do_instr({5'b00111, 27'h0ab_cdef}, 0, 1'b0);

    // Random instruction mix and wait states.
    for (int n = 0; n < 24; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        op = 5'b00001;
      end else if (r < 8) begin
        op = 5'b00010;
      end else begin
        do op = 5'($urandom_range(0, 31));
        while (op == 5'b00001 || op == 5'b00010 || op == 5'b11111);
      end
      word = {op, 27'($urandom)};
      do_instr(word, int'($urandom_range(0, 3)), 1'b0);
    end

    // run dropped during EXECUTE: completes, then idles.
    do_instr(32'h0800_0011, 1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("idle_req", 32'(imem_req), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_pc", pc, exp_pc);
      @(negedge CLK);
    end

    // Reset pulsed during FETCH acts immediately.
    run = 1'b1;
    wait_req();
    RESET = 1'b1;
    #1;
    check("async_rst_req", 32'(imem_req), 32'd0);
    check("async_rst_pc", pc, 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    apply_reset();

    // HALT opcode: terminal, run ignored.
    run = 1'b1;
    do_instr(32'hF800_0000, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run = 1'(i % 2);
      @(negedge CLK);
      check("halt_stay", 32'(halted), 32'd1);
      check("halt_noreq", 32'(imem_req), 32'd0);
      check("halt_pc_hold", pc, 32'd0);
    end

    // Fetch timeout with no ack at all.
    apply_reset();
    run = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40 && !halted; i++) begin
      if (imem_req) cnt++;
      @(negedge CLK);
    end
    check("to_cycles", 32'(cnt), 32'd15);
    check("to_flag", 32'(mem_timeout), 32'd1);
    check("to_halted", 32'(halted), 32'd1);
    check("to_req", 32'(imem_req), 32'd0);
    check("to_ill", 32'(illegal_op), 32'd0);

`ifdef PERF_COUNTER_EN
    // Five instructions with two wait cycles each.
    apply_reset();
    run = 1'b1;
    for (int n = 0; n < 5; n++) begin
      do_instr(32'h0800_0100 + 32'(n), 2, n == 4);
    end
    @(negedge CLK);
    check("perf_retired", retired_count, 32'd5);
    check("perf_stall", stall_count, 32'd10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control sequencer for the processor datapath: control_unit, aluControl_unit, alu, registerFile and the write-register/write-data muxes.
- Fetches each instruction over a req/ack memory handshake and holds it in an instruction register.
- Steps each instruction through DECODE, EXECUTE and WRITEBACK, and gates regWrite to a single WRITEBACK cycle.
- Replaces the free-running combinational regWrite path so register writes are clean and the datapath can tolerate slow instruction memory.

Parameters:
- PC_WIDTH, 32, width of the program counter and the memory address.
- PC_STEP, 4, PC increment per retired instruction.
- RESET_PC, 0, PC value loaded on reset.
- MEM_TIMEOUT, 15, maximum FETCH cycles without imem_ack before the fault path is taken (range 1..255).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- run  in  1  level enable; the sequencer leaves IDLE only while run=1.
- imem_req  out  1  fetch request; held high until acknowledged.
- imem_addr  out  PC_WIDTH  fetch address; equals pc.
- imem_ack  in  1  memory has valid data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- instr  out  32  instruction register, driving decode/ALU/register-file fields.
- pc  out  PC_WIDTH  current program counter.
- reg_write  out  1  register-file write enable; a one-cycle pulse.
- sel_t  out  1  1 = T-type (drives C_ART_reg and C_ART_data).
- busy  out  1  high in every state except IDLE and HALTED.
- halted  out  1  high in HALTED.
- illegal_op  out  1  sticky undefined-opcode flag.
- mem_timeout  out  1  sticky fetch-timeout flag.

Behaviour:
- Reset values: pc=RESET_PC; instr=0; imem_req=0; reg_write=0; sel_t=0; busy=0; halted=0; illegal_op=0; mem_timeout=0; state=IDLE; timeout counter=0.
- Reset asserted mid-operation forces all of these values immediately; imem_req drops without waiting for the edge.
- Opcode constants, decoded from instr[31:27]:
  - OP_AR = 5'b00001
  - OP_T = 5'b00010
  - OP_HALT = 5'b11111
  - any other value is illegal.
- IDLE: go to FETCH when run=1.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - On an edge with imem_ack=1: instr<=imem_rdata, counter cleared, go to DECODE.
  - Otherwise the counter increments. When the counter reaches MEM_TIMEOUT-1 with no ack: mem_timeout<=1, go to HALTED.
  - imem_req is deasserted in every state other than FETCH.
- DECODE (1 cycle): sel_t<=(opcode==OP_T).
  - OP_HALT: go to HALTED; pc is not advanced.
  - Illegal opcode: illegal_op<=1, go to WRITEBACK with the write suppressed.
  - Otherwise: go to EXECUTE.
- EXECUTE (1 cycle): instr and sel_t are held stable so the ALU and sign-extend paths settle.
- WRITEBACK (1 cycle):
  - reg_write=1 for OP_AR or OP_T only.
  - pc<=pc+PC_STEP, wrapping modulo 2^PC_WIDTH.
  - Next state is FETCH if run=1, IDLE if run=0.
- Deasserting run mid-instruction does not abort; the current instruction completes and the sequencer stops at the end of WRITEBACK.
- HALTED: terminal; only RESET exits.
- Minimum latency: 4 cycles per instruction with ack in the first FETCH cycle. Each extra wait cycle adds 1.
- An imem_ack outside FETCH is ignored.

Optional Feature:
- Macro: PERF_COUNTER_EN.
- Defined:
  - Adds output retired_count, 32 bits, reset 0.
  - Increments once per WRITEBACK cycle, including illegal-opcode instructions, and saturates at 32'hFFFF_FFFF.
  - Also adds output stall_count, 32 bits, reset 0, incremented on each FETCH cycle without imem_ack; it also saturates.
- Undefined: neither port exists and the logic is absent.

Decomposition:
- Shared package (proc_pkg): OP_AR, OP_T and OP_HALT opcode constants; state encoding (IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED, 3 bits); instruction field bit ranges.
- The same package is later consumed by control_unit.
- One natural sub-module: fetch_timer (timeout counter with clear, enable and expired outputs).
- The FSM stays in the top module.

Test Plan:
- Ack timing: after reset release with run=1, memory acks the same cycle with 32'h08000000 (OP_AR).
  - Required: reg_write pulses exactly once, 3 cycles after the ack edge.
  - Required: pc goes 0 -> 4, and the next fetch address is 4.
- T-type: fetch 32'h10080005 (OP_T).
  - Required: sel_t=1 from DECODE through WRITEBACK, and reg_write pulses once.
- Memory wait states: ack delayed 3 cycles.
  - Required: imem_req stays high for 4 cycles and the instruction completes in 7 cycles.
  - Required: with MEM_TIMEOUT=15 and no ack, mem_timeout=1 and halted=1 after 15 FETCH cycles.
- Illegal/HALT opcodes:
  - Opcode 5'b00111: illegal_op=1, no reg_write, pc advances by 4.
  - Opcode 5'b11111: halted=1 with pc unchanged, and the sequencer ignores run until RESET.
- run and reset mid-instruction:
  - run dropped during EXECUTE: the instruction finishes with reg_write and the sequencer enters IDLE.
  - RESET pulsed during FETCH: imem_req=0 immediately and pc=RESET_PC.
- With PERF_COUNTER_EN: run 5 instructions with 2 wait cycles each.
  - Required: retired_count=5 and stall_count=10.
